// File: rtl/sprite_layer_if.sv
// rtl/sprite_layer_if.sv - position handshake and bitmap write port of the sprite layer
interface sprite_layer_if #(
    parameter int AW = 10
);
    logic [11:0]   pos_x;
    logic [11:0]   pos_y;
    logic          pos_valid;
    logic          pos_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;

    modport master (
        output pos_x, pos_y, pos_valid, wr_en, wr_addr, wr_data,
        input  pos_ready
    );

    modport slave (
        input  pos_x, pos_y, pos_valid, wr_en, wr_addr, wr_data,
        output pos_ready
    );
endinterface

// File: rtl/sprite_layer.sv
// rtl/sprite_layer.sv - single keyed sprite RGBA layer with vblank-committed position
module sprite_layer #(
    parameter int          SPR_W     = 32,
    parameter int          SPR_H     = 32,
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [11:0]  hdata,
    input  logic [11:0]  vdata,
    input  logic         valid,
    input  logic         enable,
    sprite_layer_if.slave bus,
    output logic [3:0]   R,
    output logic [3:0]   G,
    output logic [3:0]   B,
    output logic         A,
    output logic         valid_out
);
    localparam int DEPTH = SPR_W * SPR_H;
    localparam int AW    = $clog2(DEPTH);
    localparam int XW    = $clog2(SPR_W);
    localparam int YW    = AW - XW;

    typedef enum logic {EMPTY, PENDING} pos_state_t;

    pos_state_t    state, state_next;
    logic [11:0]   pend_x, pend_y, act_x, act_y, vdata_q;
    logic          frame_start;
    logic signed [12:0] dx, dy;
    logic          in_x, in_y, hit, hit_q, valid_q, opaque;
    logic [AW-1:0] rd_addr;
    logic [11:0]   texel;
    logic [11:0]   mem [DEPTH];

    // One pulse per frame: the first cycle vdata leaves the active region.
    assign frame_start = (vdata_q < 12'(V_ACTIVE)) && (vdata >= 12'(V_ACTIVE));

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (bus.pos_valid) state_next = PENDING;
            PENDING: if (frame_start)   state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign bus.pos_ready = (state == EMPTY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EMPTY;
            vdata_q <= 12'(V_ACTIVE);
            pend_x  <= '0;
            pend_y  <= '0;
            act_x   <= 12'(H_ACTIVE);
            act_y   <= 12'(V_ACTIVE);
        end else begin
            state   <= state_next;
            vdata_q <= vdata;
            if (state == EMPTY && bus.pos_valid) begin
                pend_x <= bus.pos_x;
                pend_y <= bus.pos_y;
            end
            if (state == PENDING && frame_start) begin
                act_x <= pend_x;
                act_y <= pend_y;
            end
        end
    end

    // Zero-extended subtraction: a negative offset sets bit 12, so nothing wraps.
    assign dx      = $signed({1'b0, hdata}) - $signed({1'b0, act_x});
    assign dy      = $signed({1'b0, vdata}) - $signed({1'b0, act_y});
    assign in_x    = !dx[12] && (dx[11:0] < 12'(SPR_W));
    assign in_y    = !dy[12] && (dy[11:0] < 12'(SPR_H));
    assign hit     = valid && enable && in_x && in_y;
    assign rd_addr = {dy[YW-1:0], dx[XW-1:0]};

    // Bitmap survives reset; the read register doubles as the stage-1 address register.
    always_ff @(posedge clk) begin
        if (bus.wr_en && ({1'b0, bus.wr_addr} < (AW+1)'(DEPTH)))
            mem[bus.wr_addr] <= bus.wr_data;
        texel <= mem[rd_addr];
    end

    assign opaque = hit_q && (texel != KEY_COLOR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q     <= 1'b0;
            valid_q   <= 1'b0;
            A         <= 1'b0;
            R         <= '0;
            G         <= '0;
            B         <= '0;
            valid_out <= 1'b0;
        end else begin
            hit_q     <= hit;
            valid_q   <= valid;
            A         <= opaque;
            {R, G, B} <= opaque ? texel : 12'h000;
            valid_out <= valid_q;
        end
    end
endmodule

// File: tb/tb_sprite_layer.sv
// tb/tb_sprite_layer.sv - scoreboard bench for sprite_layer over sparse pixel scans
module tb_sprite_layer;
    localparam int W     = 32;
    localparam int H     = 30;   // non-power-of-two height leaves addresses >= W*H representable
    localparam int DEPTH = W * H;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [11:0] KEY = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] hdata, vdata;
    logic        valid, enable;
    logic [3:0]  r, g, b;
    logic        a, valid_out;

    sprite_layer_if #(.AW(AW)) bus ();

    sprite_layer #(.SPR_W(W), .SPR_H(H), .H_ACTIVE(640), .V_ACTIVE(480), .KEY_COLOR(KEY)) dut (
        .clk(clk), .rst_n(rst_n), .hdata(hdata), .vdata(vdata), .valid(valid), .enable(enable),
        .bus(bus), .R(r), .G(g), .B(b), .A(a), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int x; int y; logic [12:0] val;} exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic [11:0] mem_m [DEPTH];
    int exp_ax, exp_ay, pend_ax, pend_ay;
    bit pend_full;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [12:0] expect_px(input int x, input int y);
        logic [11:0] t;
        if (!(enable && x >= exp_ax && x < exp_ax + W && y >= exp_ay && y < exp_ay + H))
            return 13'h0;
        t = mem_m[(y - exp_ay) * W + (x - exp_ax)];
        return (t == KEY) ? 13'h0 : {1'b1, t};
    endfunction

    always @(negedge clk) begin
        if (valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected_valid_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("latency(%0d,%0d)", mon_e.x, mon_e.y), 32'(cyc), 32'(mon_e.cyc));
                check($sformatf("pixel(%0d,%0d)", mon_e.x, mon_e.y), 32'({a, r, g, b}), 32'(mon_e.val));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y);
        exp_t e;
        hdata = 12'(x); vdata = 12'(y); valid = 1'b1;
        e.cyc = cyc + 2; e.x = x; e.y = y; e.val = expect_px(x, y);
        sb.push_back(e);
        step();
    endtask

    task automatic idle(input int n);
        valid = 1'b0; hdata = '0;
        repeat (n) step();
    endtask

    task automatic scan(input int ax, input int ay);
        int xs[8];
        int ys[7];
        xs = '{0, ax - 1, ax, ax + 1, ax + 5, ax + W - 1, ax + W, 639};
        ys = '{0, ay - 1, ay, ay + 1, ay + H - 1, ay + H, 479};
        foreach (ys[j])
            foreach (xs[i])
                if (xs[i] >= 0 && xs[i] < 640 && ys[j] >= 0 && ys[j] < 480)
                    pix(xs[i], ys[j]);
        idle(3);
    endtask

    task automatic end_frame();
        vdata = 12'd479; idle(3);
        vdata = 12'd480; step();
        if (pend_full) begin
            exp_ax = pend_ax; exp_ay = pend_ay; pend_full = 0;
        end
        vdata = 12'd481; step(); step();
    endtask

    task automatic submit(input int x, input int y);
        bus.pos_x = 12'(x); bus.pos_y = 12'(y); bus.pos_valid = 1'b1;
        check("submit_ready", 32'(bus.pos_ready), 32'd1);
        step();
        bus.pos_valid = 1'b0;
        pend_ax = x; pend_ay = y; pend_full = 1;
    endtask

    task automatic wr(input int addr, input logic [11:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = AW'(addr); bus.wr_data = data;
        step();
        bus.wr_en = 1'b0;
        if (addr < DEPTH) mem_m[addr] = data;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_A"}, 32'(a), 32'd0);
        check({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
        check({tag, "_valid_out"}, 32'(valid_out), 32'd0);
        check({tag, "_pos_ready"}, 32'(bus.pos_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; hdata = '0; vdata = '0; valid = 1'b0; enable = 1'b1;
        bus.pos_valid = 1'b0; bus.pos_x = '0; bus.pos_y = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        exp_ax = 640; exp_ay = 480; pend_full = 0;

        repeat (3) begin
            hdata = 12'($urandom); vdata = 12'($urandom); valid = 1'($urandom);
            enable = 1'($urandom); bus.pos_valid = 1'($urandom);
            bus.pos_x = 12'($urandom); bus.pos_y = 12'($urandom);
            step();
        end
        check_idle_outputs("reset");
        rst_n = 1'b1; valid = 1'b0; enable = 1'b1; bus.pos_valid = 1'b0; vdata = 12'd481;
        step();
        scan(100, 50);
        end_frame();

        for (int i = 0; i < DEPTH; i++) wr(i, 12'h123);
        submit(100, 50);
        scan(100, 50);
        end_frame();
        scan(100, 50);

        wr(0, KEY);
        scan(100, 50);
        enable = 1'b0;
        scan(100, 50);
        enable = 1'b1;

        submit(200, 100);
        bus.pos_x = 12'd300; bus.pos_y = 12'd150; bus.pos_valid = 1'b1;
        check("pending_not_ready", 32'(bus.pos_ready), 32'd0);
        step();
        scan(100, 50);
        vdata = 12'd479; idle(3);
        vdata = 12'd480;
        check("ready_at_boundary", 32'(bus.pos_ready), 32'd0);
        step();
        exp_ax = 200; exp_ay = 100; pend_full = 0;
        check("ready_after_boundary", 32'(bus.pos_ready), 32'd1);
        vdata = 12'd481; step();
        bus.pos_valid = 1'b0;
        pend_ax = 300; pend_ay = 150; pend_full = 1;
        check("second_request_taken", 32'(bus.pos_ready), 32'd0);
        step();
        scan(200, 100);
        end_frame();
        scan(300, 150);

        submit(624, 470);
        end_frame();
        scan(624, 470);
        submit(640, 0);
        end_frame();
        scan(624, 470);
        scan(640, 0);

        submit(100, 50);
        end_frame();
        wr(DEPTH, 12'hABC);
        wr(1023, 12'hABC);
        wr(DEPTH - 1, 12'h7E1);
        for (int x = 100; x < 105; x++) pix(x, 50);
        bus.wr_en = 1'b1; bus.wr_addr = AW'(5); bus.wr_data = 12'h456;
        pix(105, 50);
        bus.wr_en = 1'b0;
        mem_m[5] = 12'h456;
        pix(106, 50);
        idle(3);
        end_frame();
        scan(100, 50);

        submit(300, 200);
        pix(101, 50);
        pix(102, 50);
        rst_n = 1'b0; valid = 1'b0;
        step();
        void'(sb.pop_back());
        check_idle_outputs("midframe_reset");
        rst_n = 1'b1;
        exp_ax = 640; exp_ay = 480; pend_full = 0;
        step();
        scan(100, 50);
        end_frame();
        scan(300, 200);
        submit(100, 50);
        end_frame();
        scan(100, 50);

        idle(5);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
